// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, taken-branch flush and memory-wait freeze control for a 5-stage pipe.
// Defining HAZARD_PERF_CNT_EN adds the stall_cycles / flush_events performance counters.
module pipeline_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int BR_FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_wr_reg,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  hz_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, BR_FLUSH, MEM_WAIT} state_e;
  localparam logic [2:0] LU_CNT = 3'(LU_STALL_CYCLES - 1);
  localparam logic [2:0] BR_CNT = 3'(BR_FLUSH_CYCLES - 1);
  state_e state_q, state_d, saved_q, saved_d, eff;
  logic [2:0] cnt_q, cnt_d;
  logic lu, mb, freeze;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, ifid_flush_c, idex_flush_c;
  assign lu = ex_mem_read & ex_reg_write & (ex_wr_reg != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_wr_reg)) | (id_uses_rs2 & (id_rs2 == ex_wr_reg)));
  assign mb = mem_req & ~mem_ready;
  // On release from MEM_WAIT the controller acts as the state it interrupted
  assign eff = (state_q == MEM_WAIT) ? saved_q : state_q;
  assign freeze = mb | ((state_q == MEM_WAIT) & ~mem_ready);
  always_comb begin
    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b1111;
    {ifid_flush_c, idex_flush_c} = 2'b00;
    state_d = state_q;
    saved_d = saved_q;
    cnt_d = cnt_q;
    if (freeze) begin
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
      state_d = MEM_WAIT;
      saved_d = eff;
    end else if (eff == RUN) begin
      state_d = RUN;
      if (ex_branch_taken) begin
        {ifid_flush_c, idex_flush_c} = 2'b11;
        if (BR_FLUSH_CYCLES > 1) begin
          state_d = BR_FLUSH;
          cnt_d = BR_CNT;
        end
      end else if (lu) begin
        {pc_en_c, ifid_en_c, idex_flush_c} = 3'b001;
        if (LU_STALL_CYCLES > 1) begin
          state_d = LOAD_STALL;
          cnt_d = LU_CNT;
        end
      end
    end else begin
      pc_en_c = eff == BR_FLUSH;
      ifid_en_c = eff == BR_FLUSH;
      ifid_flush_c = eff == BR_FLUSH;
      idex_flush_c = 1'b1;
      cnt_d = cnt_q - 3'd1;
      state_d = (cnt_q == 3'd1) ? RUN : eff;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q <= cnt_d;
    end
  end
  assign pc_en = rst_n & pc_en_c;
  assign ifid_en = rst_n & ifid_en_c;
  assign idex_en = rst_n & idex_en_c;
  assign exmem_en = rst_n & exmem_en_c;
  assign ifid_flush = rst_n & ifid_flush_c;
  assign idex_flush = rst_n & idex_flush_c;
  assign hz_state = rst_n ? state_q : 2'd0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;
  logic br_acc;
  assign br_acc = ~freeze & (eff == RUN) & ex_branch_taken;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      stall_q <= stall_q + {31'd0, ~pc_en_c};
      flush_q <= flush_q + {31'd0, br_acc};
    end
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, hand sequences and random run against a counting reference model.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_wr_reg;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write, ex_branch_taken, mem_req, mem_ready;
  logic pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, ifid_flush_a, idex_flush_a;
  logic pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, ifid_flush_b, idex_flush_b;
  logic [1:0] hz_state_a, hz_state_b;
  logic [31:0] stall_cycles_a, flush_events_a, stall_cycles_b, flush_events_b;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct packed {
    logic [4:0] rs1, rs2, wr;
    logic u1, u2, mr, rw, br, req, rdy;
  } in_t;
  typedef struct {
    logic [3:0] en;
    logic [1:0] fl, st;
    logic [31:0] sc, fe;
  } out_t;
  typedef struct {in_t x; out_t e;} vec_t;
  typedef struct {int ws, wf, sc, fe; bit w;} ms_t;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_wr_reg(ex_wr_reg),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en_a), .ifid_en(ifid_en_a),
    .idex_en(idex_en_a), .exmem_en(exmem_en_a), .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
    .hz_state(hz_state_a), .stall_cycles(stall_cycles_a), .flush_events(flush_events_a)
  );
  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .BR_FLUSH_CYCLES(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_wr_reg(ex_wr_reg),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en_b), .ifid_en(ifid_en_b),
    .idex_en(idex_en_b), .exmem_en(exmem_en_b), .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
    .hz_state(hz_state_b), .stall_cycles(stall_cycles_b), .flush_events(flush_events_b)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cmp_out(string nm, out_t a, out_t e, bit perf);
    chk({nm, "_en"}, 32'(a.en), 32'(e.en));
    chk({nm, "_flush"}, 32'(a.fl), 32'(e.fl));
    chk({nm, "_state"}, 32'(a.st), 32'(e.st));
    if (perf) begin
      chk({nm, "_stall_cycles"}, a.sc, e.sc);
      chk({nm, "_flush_events"}, a.fe, e.fe);
    end
  endtask
  function automatic out_t pack_a();
    pack_a.en = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a};
    pack_a.fl = {ifid_flush_a, idex_flush_a};
    pack_a.st = hz_state_a;
    pack_a.sc = stall_cycles_a;
    pack_a.fe = flush_events_a;
  endfunction
  function automatic out_t pack_b();
    pack_b.en = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b};
    pack_b.fl = {ifid_flush_b, idex_flush_b};
    pack_b.st = hz_state_b;
    pack_b.sc = stall_cycles_b;
    pack_b.fe = flush_events_b;
  endfunction
  function automatic in_t mi(int rs1, int rs2, int wr, bit u1, bit u2, bit mr, bit rw,
                             bit br, bit req, bit rdy);
    mi.rs1 = 5'(rs1);
    mi.rs2 = 5'(rs2);
    mi.wr = 5'(wr);
    {mi.u1, mi.u2, mi.mr, mi.rw, mi.br, mi.req, mi.rdy} = {u1, u2, mr, rw, br, req, rdy};
  endfunction
  function automatic vec_t mk(in_t x, logic [3:0] en, logic [1:0] fl, logic [1:0] st);
    mk.x = x;
    mk.e.en = en;
    mk.e.fl = fl;
    mk.e.st = st;
    mk.e.sc = 32'd0;
    mk.e.fe = 32'd0;
  endfunction
  task automatic drive(in_t x);
    id_rs1 = x.rs1;
    id_rs2 = x.rs2;
    ex_wr_reg = x.wr;
    id_uses_rs1 = x.u1;
    id_uses_rs2 = x.u2;
    ex_mem_read = x.mr;
    ex_reg_write = x.rw;
    ex_branch_taken = x.br;
    mem_req = x.req;
    mem_ready = x.rdy;
  endtask
  // Reference: pending bubble / flush counts plus a "waiting on memory" flag
  task automatic mstep(inout ms_t s, input int m, input int n, input in_t x, output out_t e);
    bit lu, busy;
    lu = x.mr && x.rw && x.wr != 0 && ((x.u1 && x.rs1 == x.wr) || (x.u2 && x.rs2 == x.wr));
    busy = x.req && !x.rdy;
    e.en = 4'b1111;
    e.fl = 2'b00;
    e.st = s.w ? 2'd3 : (s.wf > 0) ? 2'd2 : (s.ws > 0) ? 2'd1 : 2'd0;
    e.sc = PERF ? 32'(s.sc) : 32'd0;
    e.fe = PERF ? 32'(s.fe) : 32'd0;
    if ((s.w && !x.rdy) || busy) begin
      e.en = 4'b0000;
      s.w = 1'b1;
    end else begin
      s.w = 1'b0;
      if (s.wf > 0) begin
        e.fl = 2'b11;
        s.wf--;
      end else if (s.ws > 0) begin
        e.en = 4'b0011;
        e.fl = 2'b01;
        s.ws--;
      end else if (x.br) begin
        e.fl = 2'b11;
        s.wf = n - 1;
        s.fe++;
      end else if (lu) begin
        e.en = 4'b0011;
        e.fl = 2'b01;
        s.ws = m - 1;
      end
    end
    if (!e.en[3]) s.sc++;
  endtask
  task automatic do_reset();
    out_t z;
    z = '{default: 0};
    rst_n = 1'b0;
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    cmp_out("rst_a", pack_a(), z, 1'b1);
    cmp_out("rst_b", pack_b(), z, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    vec_t tbl[$];
    vec_t hs[$];
    in_t idle, lu5, busy, x;
    out_t z, ea, eb;
    ms_t ma, mb;
    int pc0;
    z = '{default: 0};
    idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu5 = mi(5, 0, 5, 1, 0, 1, 1, 0, 0, 0);
    busy = mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl.push_back(mk(idle, 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(lu5, 4'b0011, 2'b01, 2'd0));
    tbl.push_back(mk(idle, 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(mi(0, 0, 0, 1, 0, 1, 1, 0, 0, 0), 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(mi(1, 7, 7, 0, 1, 1, 1, 0, 0, 0), 4'b0011, 2'b01, 2'd0));
    tbl.push_back(mk(mi(5, 5, 5, 0, 0, 1, 1, 0, 0, 0), 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(mi(5, 0, 5, 1, 0, 1, 0, 0, 0, 0), 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(mi(5, 0, 5, 1, 0, 0, 1, 0, 0, 0), 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(mi(5, 0, 5, 1, 0, 1, 1, 1, 0, 0), 4'b1111, 2'b11, 2'd0));
    tbl.push_back(mk(mi(5, 0, 5, 1, 0, 1, 1, 1, 0, 0), 4'b1111, 2'b11, 2'd2));
    tbl.push_back(mk(idle, 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(busy, 4'b0000, 2'b00, 2'd0));
    tbl.push_back(mk(busy, 4'b0000, 2'b00, 2'd3));
    tbl.push_back(mk(busy, 4'b0000, 2'b00, 2'd3));
    tbl.push_back(mk(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 4'b1111, 2'b00, 2'd3));
    tbl.push_back(mk(idle, 4'b1111, 2'b00, 2'd0));
    tbl.push_back(mk(mi(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 4'b0000, 2'b00, 2'd0));
    tbl.push_back(mk(mi(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 4'b1111, 2'b11, 2'd3));
    tbl.push_back(mk(idle, 4'b1111, 2'b11, 2'd2));
    tbl.push_back(mk(idle, 4'b1111, 2'b00, 2'd0));
    hs.push_back(mk(lu5, 4'b0011, 2'b01, 2'd0));
    hs.push_back(mk(mi(5, 0, 5, 1, 0, 1, 1, 0, 1, 0), 4'b0000, 2'b00, 2'd1));
    hs.push_back(mk(mi(5, 0, 5, 1, 0, 1, 1, 0, 1, 0), 4'b0000, 2'b00, 2'd3));
    hs.push_back(mk(mi(5, 0, 5, 1, 0, 1, 1, 0, 1, 1), 4'b0011, 2'b01, 2'd3));
    hs.push_back(mk(idle, 4'b0011, 2'b01, 2'd1));
    hs.push_back(mk(idle, 4'b1111, 2'b00, 2'd0));
    hs.push_back(mk(mi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 4'b1111, 2'b11, 2'd0));
    hs.push_back(mk(idle, 4'b1111, 2'b11, 2'd2));
    hs.push_back(mk(idle, 4'b1111, 2'b00, 2'd0));
    drive(mi(5, 0, 5, 1, 0, 1, 1, 1, 1, 0));
    #3;
    cmp_out("in_reset_a", pack_a(), z, 1'b1);
    cmp_out("in_reset_b", pack_b(), z, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].x);
      #3;
      cmp_out($sformatf("vec%0d", i), pack_a(), tbl[i].e, 1'b0);
      @(posedge clk);
      #1;
    end
    #3;
    chk("vec_stall_cycles", stall_cycles_a, PERF ? 32'd6 : 32'd0);
    chk("vec_flush_events", flush_events_a, PERF ? 32'd2 : 32'd0);
    @(posedge clk);
    #1;
    do_reset();
    drive(idle);
    #3;
    cmp_out("seq3_idle", pack_b(), hs[5].e, 1'b0);
    @(posedge clk);
    #1;
    pc0 = 0;
    for (int i = 0; i < hs.size(); i++) begin
      drive(hs[i].x);
      #3;
      cmp_out($sformatf("seq3_%0d", i), pack_b(), hs[i].e, 1'b0);
      if (!pc_en_b) pc0++;
      if (i == 5) begin
        chk("seq3_stall_cycles", stall_cycles_b, PERF ? 32'd5 : 32'd0);
        chk("seq3_flush_events0", flush_events_b, 32'd0);
      end
      if (i == 7) chk("seq3_flush_events1", flush_events_b, PERF ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    chk("seq3_pc_en_low_cycles", 32'(pc0), 32'd5);
    do_reset();
    ma = '{default: 0};
    mb = '{default: 0};
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #3;
        cmp_out("rnd_rst_a", pack_a(), z, 1'b1);
        cmp_out("rnd_rst_b", pack_b(), z, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ma = '{default: 0};
        mb = '{default: 0};
      end else begin
        x = mi($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 1'($urandom));
        drive(x);
        mstep(ma, 1, 2, x, ea);
        mstep(mb, 3, 2, x, eb);
        #3;
        cmp_out("rnd_a", pack_a(), ea, 1'b1);
        cmp_out("rnd_b", pack_b(), eb, 1'b1);
        @(posedge clk);
        #1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
